bus_interconnect: RTL and testbench

//  Shared system bus directly downstream of the DMAC master port. Arbitrates between
//  M0 (CPU/testbench) and M1 (DMAC master: m_req/m_wr/m_addr/m_dout <-> m_grant/m_din).

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_addr_decoder.sv | 19 +
 rtl/bus_interconnect.sv | 65 ++++++
 tb/tb_bus_interconnect.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the two-master system bus.
//   Arbiter state encoding, slave region bases and mask widths, read-return select codes.
package bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [0:0] M0_GRANT = 1'b0;
  localparam logic [0:0] M1_GRANT = 1'b1;
  localparam logic [ADDR_W-1:0] S0_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] S1_BASE = 16'h8000;
  localparam int S0_MSK_W = 5;
  localparam int S1_MSK_W = 11;
  localparam logic [1:0] RD_S0 = 2'b01;
  localparam logic [1:0] RD_S1 = 2'b10;
endpackage

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: maps the owner's address onto at most one slave select.
//   i_addr  owner address       i_req   owner request (gates both selects)
//   o_s0_sel RAM region hit     o_s1_sel DMAC slave region hit
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int              AW   = ADDR_W,
  parameter logic [AW-1:0]   S0_B = S0_BASE,
  parameter logic [AW-1:0]   S1_B = S1_BASE
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_req,
  output logic          o_s0_sel,
  output logic          o_s1_sel
);
  // Regions are disjoint in their top bits, so at most one select can fire.
  assign o_s0_sel = i_req && (i_addr[AW-1 -: S0_MSK_W] == S0_B[AW-1 -: S0_MSK_W]);
  assign o_s1_sel = i_req && (i_addr[AW-1 -: S1_MSK_W] == S1_B[AW-1 -: S1_MSK_W]);
endmodule

// File: rtl/bus_interconnect.sv
// bus_interconnect: two-master (M0 CPU, M1 DMAC) shared bus with a non-preemptive arbiter,
//   address decode to RAM (S0) / DMAC slave (S1) and registered read-return select.
//   clk, reset_n           clock, async active-low reset
//   m{0,1}_req/wr/addr/dout  master requests;  m{0,1}_grant  bus ownership
//   m_din                  read data broadcast to both masters
//   s0_sel/s1_sel/s_wr/s_addr/s_din  slave side;  s0_dout/s1_dout  slave read data
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int                 ADDR_WIDTH = ADDR_W,
  parameter int                 DATA_WIDTH = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] S0_B    = S0_BASE,
  parameter logic [ADDR_WIDTH-1:0] S1_B    = S1_BASE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_dout,
  output logic                  m0_grant,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  m1_grant,
  output logic [DATA_WIDTH-1:0] m_din,
  output logic                  s0_sel,
  output logic                  s1_sel,
  output logic                  s_wr,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_din,
  input  logic [DATA_WIDTH-1:0] s0_dout,
  input  logic [DATA_WIDTH-1:0] s1_dout
);
  logic [0:0] r_state;
  logic [1:0] r_rd_sel;
  logic       w_own_req;
  logic [0:0] w_nxt;
  assign m0_grant  = (r_state == M0_GRANT);
  assign m1_grant  = (r_state == M1_GRANT);
  assign w_own_req = m1_grant ? m1_req  : m0_req;
  assign s_addr    = m1_grant ? m1_addr : m0_addr;
  assign s_din     = m1_grant ? m1_dout : m0_dout;
  // A parked owner with req low must not write.
  assign s_wr      = w_own_req & (m1_grant ? m1_wr : m0_wr);
  // M1 takes the bus only when M0 is idle; M1 keeps it while it requests.
  assign w_nxt     = m1_grant ? m1_req : (~m0_req & m1_req);
  bus_addr_decoder #(.AW(ADDR_WIDTH), .S0_B(S0_B), .S1_B(S1_B)) u_dec (
    .i_addr  (s_addr),
    .i_req   (w_own_req),
    .o_s0_sel(s0_sel),
    .o_s1_sel(s1_sel)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= M0_GRANT;
      r_rd_sel <= 2'b00;
    end else begin
      r_state  <= w_nxt;
      r_rd_sel <= {s1_sel & ~s_wr, s0_sel & ~s_wr};
    end
  // Read data follows the previous address phase, even across an ownership switch.
  assign m_din = (r_rd_sel == RD_S0) ? s0_dout : (r_rd_sel == RD_S1) ? s1_dout : '0;
endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_dout = 0, m1_dout = 0;
  logic        m0_grant, m1_grant, s0_sel, s1_sel, s_wr;
  logic [31:0] m_din, s_din, s0_dout;
  logic [31:0] s1_dout = 32'h1;
  logic [15:0] s_addr;
  logic [31:0] mem [0:511];
  logic [31:0] sb [$];
  int          n_chk = 0, n_err = 0;
  bit          pend = 0;

  bus_interconnect dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout), .m0_grant(m0_grant),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout), .m1_grant(m1_grant),
    .m_din(m_din), .s0_sel(s0_sel), .s1_sel(s1_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s0_dout(s0_dout), .s1_dout(s1_dout)
  );

  always #5 clk = ~clk;

  // RAM slave: synchronous write, registered read (data one cycle after address).
  always @(posedge clk) begin
    if (s0_sel && s_wr) mem[s_addr[10:2]] <= s_din;
    s0_dout <= mem[s_addr[10:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic m0(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
    m0_req = r; m0_wr = w; m0_addr = a; m0_dout = d;
  endtask

  task automatic m1(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
    m1_req = r; m1_wr = w; m1_addr = a; m1_dout = d;
  endtask

  // Monitor: a mapped read in one cycle presents data on m_din the next cycle.
  initial forever begin
    @(negedge clk);
    if (!reset_n) pend = 0;
    else begin
      if (pend) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got %h expected no read", m_din);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          if (m_din !== e) begin
            n_err++;
            $display("FAIL rd_data: got %h expected %h", m_din, e);
          end
        end
      end
      pend = (s0_sel | s1_sel) & ~s_wr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    neg;
    chk("rst_g0", {31'b0, m0_grant}, 1);
    chk("rst_g1", {31'b0, m1_grant}, 0);
    chk("rst_din", m_din, 0);
    chk("rst_sel", {30'b0, s1_sel, s0_sel}, 0);
    chk("rst_wr", {31'b0, s_wr}, 0);
    nxt; reset_n = 1;
    // M0 write then read back
    nxt; m0(1, 1, 16'h0010, 32'hDEADBEEF); neg;
    chk("wr_s0sel", {31'b0, s0_sel}, 1);
    chk("wr_s1sel", {31'b0, s1_sel}, 0);
    chk("wr_swr", {31'b0, s_wr}, 1);
    chk("wr_sdin", s_din, 32'hDEADBEEF);
    chk("wr_saddr", {16'b0, s_addr}, 32'h10);
    nxt; m0(1, 0, 16'h0010, 0); sb.push_back(32'hDEADBEEF); neg;
    chk("rd_s0sel", {31'b0, s0_sel}, 1);
    chk("rd_swr", {31'b0, s_wr}, 0);
    nxt; m0(0, 0, 0, 0); neg;
    chk("idle_s0sel", {31'b0, s0_sel}, 0);
    // M1 request while M0 idle
    nxt; m1(1, 0, 16'h8000, 0); neg;
    chk("m1_lat_g0", {31'b0, m0_grant}, 1);
    chk("m1_lat_s1", {31'b0, s1_sel}, 0);
    nxt; sb.push_back(32'h1); neg;
    chk("m1_g1", {31'b0, m1_grant}, 1);
    chk("m1_s1sel", {31'b0, s1_sel}, 1);
    chk("m1_saddr", {16'b0, s_addr}, 32'h8000);
    nxt; m1(0, 0, 0, 0); neg;
    chk("m1_drop_g1", {31'b0, m1_grant}, 1);
    chk("m1_drop_s1", {31'b0, s1_sel}, 0);
    nxt; neg;
    chk("m1_rel_g0", {31'b0, m0_grant}, 1);
    // Both request from reset
    nxt; reset_n = 0; m0(1, 1, 16'h0020, 32'h11111111); m1(1, 0, 16'h8004, 0); #1;
    chk("both_rst_g0", {31'b0, m0_grant}, 1);
    nxt; reset_n = 1; neg;
    chk("both_g0", {31'b0, m0_grant}, 1);
    chk("both_swr", {31'b0, s_wr}, 1);
    chk("both_saddr", {16'b0, s_addr}, 32'h20);
    nxt; neg;
    chk("both_hold_g0", {31'b0, m0_grant}, 1);
    chk("both_hold_g1", {31'b0, m1_grant}, 0);
    nxt; m0(0, 0, 0, 0); neg;
    chk("park_g0", {31'b0, m0_grant}, 1);
    chk("park_swr", {31'b0, s_wr}, 0);
    chk("park_sel", {30'b0, s1_sel, s0_sel}, 0);
    nxt; sb.push_back(32'h1); neg;
    chk("sw_g1", {31'b0, m1_grant}, 1);
    chk("sw_s1sel", {31'b0, s1_sel}, 1);
    nxt; m0(1, 0, 16'h0010, 0); sb.push_back(32'h1); neg;
    chk("nopre_g1", {31'b0, m1_grant}, 1);
    chk("nopre_g0", {31'b0, m0_grant}, 0);
    chk("nopre_saddr", {16'b0, s_addr}, 32'h8004);
    nxt; m0(0, 0, 0, 0); m1(0, 0, 0, 0); neg;
    chk("bdrop_g1", {31'b0, m1_grant}, 1);
    nxt; neg;
    chk("bdrop_g0", {31'b0, m0_grant}, 1);
    nxt; m0(1, 0, 16'h0020, 0); sb.push_back(32'h11111111); neg;
    nxt; m0(0, 0, 0, 0); neg;
    // Unmapped and region boundaries
    nxt; m0(1, 0, 16'h4000, 0); neg;
    chk("unm_rd_sel", {30'b0, s1_sel, s0_sel}, 0);
    nxt; m0(1, 1, 16'h4000, 32'hCAFEF00D); neg;
    chk("unm_rd_din", m_din, 0);
    chk("unm_wr_sel", {30'b0, s1_sel, s0_sel}, 0);
    chk("unm_wr_swr", {31'b0, s_wr}, 1);
    nxt; m0(1, 1, 16'h07FC, 32'hA5A5A5A5); neg;
    chk("s0_top_sel", {30'b0, s1_sel, s0_sel}, 1);
    nxt; m0(1, 1, 16'h0800, 32'h5A5A5A5A); neg;
    chk("s0_past_sel", {30'b0, s1_sel, s0_sel}, 0);
    nxt; m0(1, 0, 16'h801F, 0); sb.push_back(32'h1); neg;
    chk("s1_top_sel", {30'b0, s1_sel, s0_sel}, 2);
    nxt; m0(1, 0, 16'h8020, 0); neg;
    chk("s1_past_sel", {30'b0, s1_sel, s0_sel}, 0);
    nxt; m0(1, 0, 16'h07FC, 0); sb.push_back(32'hA5A5A5A5); neg;
    chk("s1_past_din", m_din, 0);
    nxt; m0(0, 0, 0, 0); neg;
    // Reset in the middle of an M1 read burst
    nxt; m1(1, 0, 16'h8000, 0); neg;
    nxt; sb.push_back(32'h1); neg;
    chk("burst_g1", {31'b0, m1_grant}, 1);
    nxt; neg;
    nxt; reset_n = 0; #1;
    chk("mid_rst_g0", {31'b0, m0_grant}, 1);
    chk("mid_rst_g1", {31'b0, m1_grant}, 0);
    chk("mid_rst_din", m_din, 0);
    chk("mid_rst_sel", {30'b0, s1_sel, s0_sel}, 0);
    chk("mid_rst_swr", {31'b0, s_wr}, 0);
    nxt; reset_n = 1; neg;
    chk("post_rst_g0", {31'b0, m0_grant}, 1);
    nxt; sb.push_back(32'h1); neg;
    chk("post_rst_g1", {31'b0, m1_grant}, 1);
    chk("post_rst_s1", {31'b0, s1_sel}, 1);
    nxt; m1(0, 0, 0, 0); neg;
    nxt; neg;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
